// File: rtl/tt_dpll_pkg.sv
// Shared DPLL test-wrapper definitions: scan FSM state type and default chain length.
package tt_dpll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scan_state_t;

  localparam int TT_SCAN_CHAIN_LEN = 32;

endpackage

// File: rtl/tt_scan_ctrl_if.sv
// Request/response bus of the scan-chain master.
// master = requester (test wrapper), slave = tt_scan_ctrl.
interface tt_scan_ctrl_if
  import tt_dpll_pkg::*;
#(
  parameter int CHAIN_LEN = TT_SCAN_CHAIN_LEN,
  parameter int CAP_W     = 8
);
  logic                 i_start;
  logic [CHAIN_LEN-1:0] i_wdata;
  logic [CAP_W-1:0]     i_capture_cycles;
  logic [CHAIN_LEN-1:0] i_expect;
  logic [CHAIN_LEN-1:0] i_mask;
  logic                 o_busy;
  logic                 o_done;
  logic [CHAIN_LEN-1:0] o_rdata;
  logic                 o_mismatch;

  modport master (
    output i_start, i_wdata, i_capture_cycles, i_expect, i_mask,
    input  o_busy, o_done, o_rdata, o_mismatch
  );

  modport slave (
    input  i_start, i_wdata, i_capture_cycles, i_expect, i_mask,
    output o_busy, o_done, o_rdata, o_mismatch
  );
endinterface

// File: rtl/tt_scan_shreg.sv
// Paired transmit/receive shifters. tx shifts out LSB first; rx fills from the MSB,
// so after N shifts rx[0] holds the first bit received. Next-state values are exported
// so the controller can register its outputs from them in the same edge.
module tt_scan_shreg #(
  parameter int N = 32
) (
  input  logic         o_clk_gen,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] wdata,
  input  logic         ser_in,
  output logic         tx_lsb_nxt,
  output logic [N-1:0] rx_nxt
);
  logic [N-1:0] tx, rx, tx_nxt;

  // next-state of both shifters; load and shift are never asserted together
  always_comb begin
    tx_nxt = tx;
    rx_nxt = rx;
    if (load)       tx_nxt = wdata;
    else if (shift) tx_nxt = {1'b0, tx[N-1:1]};
    if (shift)      rx_nxt = {ser_in, rx[N-1:1]};
  end

  assign tx_lsb_nxt = tx_nxt[0];

  // shifter registers
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx <= '0;
      rx <= '0;
    end else begin
      tx <= tx_nxt;
      rx <= rx_nxt;
    end
  end
endmodule

// File: rtl/tt_scan_ctrl.sv
// Scan-chain master for the DPLL test chain: shifts a CHAIN_LEN-bit word in while
// unloading the old chain contents, then runs C functional capture cycles.
// Optional unload compare: define TT_SCAN_CTRL_COMPARE_EN.
// All outputs are registered from the FSM next state so they are glitch-free.
module tt_scan_ctrl
  import tt_dpll_pkg::*;
#(
  parameter int CHAIN_LEN = TT_SCAN_CHAIN_LEN,
  parameter int CAP_W     = 8
) (
  input  logic          o_clk_gen,
  input  logic          i_rst_n,
  tt_scan_ctrl_if.slave bus,
  input  logic          i_scan_out,
  output logic          o_scan_en,
  output logic          o_scan_in
);
  localparam int SW = $clog2(CHAIN_LEN + 1);

  scan_state_t          st, st_nxt;
  logic [SW-1:0]        sh_cnt;
  logic [CAP_W-1:0]     cap_cnt;
  logic                 load, shift, last_shift;
  logic                 tx_lsb_nxt;
  logic [CHAIN_LEN-1:0] rx_nxt;
  logic                 busy_q, done_q, mism_q;
  logic [CHAIN_LEN-1:0] rdata_q;

  assign last_shift = (sh_cnt == SW'(CHAIN_LEN - 1));

  // state register
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) st <= IDLE;
    else          st <= st_nxt;
  end

  // next state and datapath strobes; DONE accepts a new start for back-to-back ops
  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    shift  = 1'b0;
    case (st)
      IDLE: if (bus.i_start) begin
        load   = 1'b1;
        st_nxt = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_shift) st_nxt = (cap_cnt != '0) ? CAPTURE : DONE;
      end
      CAPTURE: if (cap_cnt == CAP_W'(1)) st_nxt = DONE;
      DONE: begin
        if (bus.i_start) begin
          load   = 1'b1;
          st_nxt = SHIFT;
        end else begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // shift counter runs 0..CHAIN_LEN (no wrap); capture counter counts down to 1
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_cnt  <= '0;
      cap_cnt <= '0;
    end else if (load) begin
      sh_cnt  <= '0;
      cap_cnt <= bus.i_capture_cycles;
    end else begin
      if (shift)          sh_cnt  <= sh_cnt + SW'(1);
      if (st == CAPTURE)  cap_cnt <= cap_cnt - CAP_W'(1);
    end
  end

  tt_scan_shreg #(.N(CHAIN_LEN)) u_shreg (
    .o_clk_gen  (o_clk_gen),
    .i_rst_n    (i_rst_n),
    .load       (load),
    .shift      (shift),
    .wdata      (bus.i_wdata),
    .ser_in     (i_scan_out),
    .tx_lsb_nxt (tx_lsb_nxt),
    .rx_nxt     (rx_nxt)
  );

  // registered outputs; rdata is captured on entry to DONE and held until the next DONE
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_scan_en <= 1'b0;
      o_scan_in <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      o_scan_en <= (st_nxt == SHIFT);
      o_scan_in <= (st_nxt == SHIFT) & tx_lsb_nxt;
      busy_q    <= (st_nxt == SHIFT) || (st_nxt == CAPTURE);
      done_q    <= (st_nxt == DONE);
      if (st_nxt == DONE) rdata_q <= rx_nxt;
    end
  end

`ifdef TT_SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q, mask_q;

  // expect/mask latched at the accepting edge; mismatch only asserted with done
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q  <= '0;
      mask_q <= '0;
      mism_q <= 1'b0;
    end else begin
      if (load) begin
        exp_q  <= bus.i_expect;
        mask_q <= bus.i_mask;
      end
      mism_q <= (st_nxt == DONE) && (|((rx_nxt ^ exp_q) & mask_q));
    end
  end
`else
  assign mism_q = 1'b0;
`endif

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_mismatch = mism_q;
endmodule
